// File: rtl/sg90_pwm_capture.sv
// Servo-style PWM decoder: measures high time and frame length in prescaled ticks
// and reports the pulse width as an 8-bit angle once a complete frame is legal.
module sg90_pwm_capture #(
   parameter int CLK_DIV    = 556,
   parameter int WIDTH_MIN  = 45,
   parameter int WIDTH_MAX  = 225,
   parameter int PERIOD_MIN = 1600,
   parameter int PERIOD_MAX = 2000,
   parameter int TIMEOUT    = 3600
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        pwm_in,
   output logic [7:0]  angle,
   output logic        angle_valid,
   output logic        locked,
   output logic [15:0] period,
   output logic        err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic [15:0] W_MIN      = 16'(WIDTH_MIN);
   localparam logic [15:0] W_MAX      = 16'(WIDTH_MAX);
   localparam logic [15:0] P_MIN      = 16'(PERIOD_MIN);
   localparam logic [15:0] P_MAX      = 16'(PERIOD_MAX);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
   localparam logic [15:0] CNT_SAT    = 16'hFFFF;

   logic        s1_q, s2_q, prev_q;
   logic [15:0] presc_q, presc_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] width_cap_q, width_cap_d;
   logic [1:0]  state_q, state_d;
   logic [7:0]  angle_q, angle_d;
   logic        angle_valid_q, angle_valid_d;
   logic        locked_q, locked_d;
   logic [15:0] period_q, period_d;
   logic        err_q, err_d;

   logic        rise, fall, tick, timeout_hit, legal;
   logic [15:0] meas;

   always_comb begin
      rise = s2_q & ~prev_q;
      fall = ~s2_q & prev_q;
      tick = (presc_q == DIV_LAST);

      // meas includes a tick completing on this very edge, so a measurement
      // over N clocks is floor(N / CLK_DIV) even when an edge lands on a tick.
      meas = frame_cnt_q;
      if (tick && (frame_cnt_q != CNT_SAT)) begin
         meas = frame_cnt_q + 16'd1;
      end

      presc_d     = (rise || tick) ? 16'd0 : presc_q + 16'd1;
      frame_cnt_d = rise ? 16'd0 : meas;

      timeout_hit = tick && (frame_cnt_q == TO_LAST) && (state_q != ST_IDLE);
      legal = (width_cap_q >= W_MIN) && (width_cap_q <= W_MAX) &&
              (meas >= P_MIN) && (meas <= P_MAX);

      state_d       = state_q;
      width_cap_d   = width_cap_q;
      angle_d       = angle_q;
      period_d      = period_q;
      locked_d      = locked_q;
      angle_valid_d = 1'b0;
      err_d         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_d     = ST_LOW;
               width_cap_d = meas;
            end else if (timeout_hit) begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         end
         ST_LOW: begin
            if (rise) begin
               state_d = ST_HIGH;
               if (legal) begin
                  angle_d       = 8'(width_cap_q - W_MIN);
                  period_d      = meas;
                  angle_valid_d = 1'b1;
                  locked_d      = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         prev_q        <= 1'b0;
         presc_q       <= 16'd0;
         frame_cnt_q   <= 16'd0;
         width_cap_q   <= 16'd0;
         state_q       <= ST_IDLE;
         angle_q       <= 8'd0;
         angle_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         period_q      <= 16'd0;
         err_q         <= 1'b0;
      end else begin
         s1_q          <= pwm_in;
         s2_q          <= s1_q;
         prev_q        <= s2_q;
         presc_q       <= presc_d;
         frame_cnt_q   <= frame_cnt_d;
         width_cap_q   <= width_cap_d;
         state_q       <= state_d;
         angle_q       <= angle_d;
         angle_valid_q <= angle_valid_d;
         locked_q      <= locked_d;
         period_q      <= period_d;
         err_q         <= err_d;
      end
   end

   assign angle       = angle_q;
   assign angle_valid = angle_valid_q;
   assign locked      = locked_q;
   assign period      = period_q;
   assign err         = err_q;

endmodule

// File: tb/tb_sg90_pwm_capture.sv
// Bench for sg90_pwm_capture: directed and random frames scored against a
// frame-level model that works from pin edge times in clock cycles.
module tb_sg90_pwm_capture;

   localparam int D    = 2;
   localparam int WMIN = 45;
   localparam int WMAX = 225;
   localparam int PMIN = 240;
   localparam int PMAX = 300;
   localparam int TO   = 500;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        pwm_in = 1'b0;
   logic [7:0]  angle;
   logic        angle_valid;
   logic        locked;
   logic [15:0] period;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   bit m_active = 1'b0;
   bit m_locked = 1'b0;
   int m_prev_h = 0;
   int m_prev_p = 0;
   int m_angle  = 0;
   int m_period = 0;

   sg90_pwm_capture #(
      .CLK_DIV   (D),
      .WIDTH_MIN (WMIN),
      .WIDTH_MAX (WMAX),
      .PERIOD_MIN(PMIN),
      .PERIOD_MAX(PMAX),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .pwm_in     (pwm_in),
      .angle      (angle),
      .angle_valid(angle_valid),
      .locked     (locked),
      .period     (period),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_angle"}, angle, 0);
      check_eq({tag, "_valid"}, angle_valid, 0);
      check_eq({tag, "_locked"}, locked, 0);
      check_eq({tag, "_period"}, period, 0);
      check_eq({tag, "_err"}, err, 0);
   endtask

   // One frame: pin high for h clocks, low for p-h clocks. The rise that
   // starts it closes the previous frame, whose result shows up 3 clocks later.
   task automatic run_frame(input int h, input int p);
      int  exp_valid, exp_err, w, per;
      int  seen_valid, seen_err, both, lock_fall_at;
      bit  lock_prev;
      exp_valid = 0; exp_err = 0;
      seen_valid = 0; seen_err = 0; both = 0; lock_fall_at = -1;
      if (m_active && m_prev_p <= TO * D) begin
         w   = m_prev_h / D;
         per = m_prev_p / D;
         if (w >= WMIN && w <= WMAX && per >= PMIN && per <= PMAX) begin
            exp_valid = 1;
            m_angle   = w - WMIN;
            m_period  = per;
            m_locked  = 1'b1;
         end else begin
            exp_err = 1;
         end
      end
      m_active = 1'b1;
      m_prev_h = h;
      m_prev_p = p;
      lock_prev = locked;
      for (int i = 0; i < p; i++) begin
         @(posedge clk);
         #1 pwm_in = (i < h);
         @(negedge clk);
         if (angle_valid) seen_valid++;
         if (err) seen_err++;
         if (angle_valid && err) both++;
         if (lock_prev && !locked && lock_fall_at < 0) lock_fall_at = i;
         lock_prev = locked;
      end
      check_eq("valid_pulses", seen_valid, exp_valid);
      check_eq("err_pulses", seen_err, exp_err);
      check_eq("valid_and_err", both, 0);
      if (p > 3 + D * TO) begin
         if (m_locked) check_eq("lock_fall_cycle", lock_fall_at, 3 + D * TO);
         m_locked = 1'b0;
      end
      check_eq("angle", angle, m_angle);
      check_eq("period", period, m_period);
      check_eq("locked", locked, m_locked);
   endtask

   initial begin
      int h, p;
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");

      // steady 90-degree frames
      for (int k = 0; k < 4; k++) run_frame(270, 540);
      // width extremes and one tick out on each side
      run_frame(90, 540);
      run_frame(450, 540);
      run_frame(89, 540);
      run_frame(451, 540);
      run_frame(452, 540);
      run_frame(1, 540);
      // period extremes and one tick out on each side
      run_frame(200, 480);
      run_frame(200, 600);
      run_frame(200, 478);
      run_frame(200, 602);
      run_frame(300, 540);

      for (int k = 0; k < 30; k++) begin
         p = $urandom_range(440, 640);
         h = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(60, 480);
         if (h > p - 4) h = p - 4;
         run_frame(h, p);
      end

      // stuck-high pin drops lock, then re-acquire
      run_frame(270, 540);
      run_frame(1100, 1200);
      run_frame(160, 540);
      run_frame(200, 540);
      run_frame(270, 540);

      // reset in the middle of a high phase
      run_frame(400, 540);
      @(posedge clk);
      #1 pwm_in = 1'b1;
      repeat (20) @(posedge clk);
      #3 nrst = 1'b0;
      #1 check_reset_state("midreset");
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      m_active = 1'b0; m_locked = 1'b0; m_angle = 0; m_period = 0;
      repeat (4) @(posedge clk);
      run_frame(270, 540);
      run_frame(330, 540);
      run_frame(270, 540);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
